abc_front_end: RTL and testbench

Detector front-end for the ABC coincidence counter. It takes two raw, asynchronous detector lines and synchronizes each one. It then rejects glitches shorter than a minimum width and enforces a per-channel dead time. The result is clean single-cycle pulses `x1`/`x2` that feed the counter's X1/X2 inputs directly, plus saturating counts of pulses lost to dead time.

---
 rtl/abc_pkg.sv | 17 +
 rtl/abc_if.sv | 27 ++
 rtl/abc_chan_cond.sv | 112 +++++++++++
 rtl/abc_front_end.sv | 49 ++++
 tb/tb_abc_front_end.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/abc_pkg.sv
// Shared types and default parameters for the ABC detector front-end.
package abc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FIRE,
        DEAD,
        WAIT_LOW
    } chan_state_t;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_MIN_WIDTH   = 2;
    localparam int unsigned DEF_DEAD_CYCLES = 8;
    localparam int unsigned DEF_CNT_W       = 4;

endpackage

// File: rtl/abc_if.sv
// Detector-side bundle: raw inputs in, conditioned strobes and lost counts out.
interface abc_if
    import abc_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
);

    logic             raw1;
    logic             raw2;
    logic             x1;
    logic             x2;
    logic             busy1;
    logic             busy2;
    logic [CNT_W-1:0] lost1;
    logic [CNT_W-1:0] lost2;

    modport master (
        output raw1, raw2,
        input  x1, x2, busy1, busy2, lost1, lost2
    );

    modport slave (
        input  raw1, raw2,
        output x1, x2, busy1, busy2, lost1, lost2
    );

endinterface

// File: rtl/abc_chan_cond.sv
// One detector channel: input synchronizer, width filter / dead-time FSM and
// saturating lost-pulse counter.
module abc_chan_cond
    import abc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned MIN_WIDTH   = DEF_MIN_WIDTH,
    parameter int unsigned DEAD_CYCLES = DEF_DEAD_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear_lost,
    input  logic             raw,
    output logic             x,
    output logic             busy,
    output logic [CNT_W-1:0] lost
);

    localparam int unsigned WW = $clog2(MIN_WIDTH + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   s_q;
    logic                   rise;

    chan_state_t            state;
    chan_state_t            state_n;
    logic [WW-1:0]          wcnt;
    logic [WW-1:0]          wcnt_n;
    logic [WW-1:0]          wcnt_inc;
    logic [CNT_W-1:0]       dcnt;
    logic [CNT_W-1:0]       dcnt_n;
    logic                   lost_inc;

    assign s        = sync[SYNC_STAGES-1];
    assign rise     = s & ~s_q;
    assign wcnt_inc = wcnt + WW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            s_q  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            s_q  <= s;
        end
    end

    always_comb begin
        state_n  = state;
        wcnt_n   = wcnt;
        dcnt_n   = dcnt;
        lost_inc = 1'b0;
        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        wcnt_n = WW'(1);
                        if (MIN_WIDTH == 1) state_n = FIRE;
                        else                state_n = ARM;
                    end
                end
                ARM: begin
                    if (!s) begin
                        state_n = IDLE;
                    end else begin
                        wcnt_n = wcnt_inc;
                        if (wcnt_inc == WW'(MIN_WIDTH)) state_n = FIRE;
                    end
                end
                FIRE: begin
                    state_n = DEAD;
                    dcnt_n  = '0;
                end
                DEAD: begin
                    lost_inc = rise;
                    if (dcnt == CNT_W'(DEAD_CYCLES - 1)) state_n = WAIT_LOW;
                    else                                 dcnt_n  = dcnt + CNT_W'(1);
                end
                WAIT_LOW: begin
                    if (!s) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // x and busy are registered views of the current state, so both lag it by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            wcnt  <= '0;
            dcnt  <= '0;
            x     <= 1'b0;
            busy  <= 1'b0;
            lost  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            dcnt  <= dcnt_n;
            x     <= enable && (state == FIRE);
            busy  <= (state != IDLE);
            if (clear_lost)                   lost <= '0;
            else if (lost_inc && lost != '1) lost <= lost + CNT_W'(1);
        end
    end

endmodule

// File: rtl/abc_front_end.sv
// Two independent conditioned detector channels feeding the coincidence counter.
module abc_front_end
    import abc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned MIN_WIDTH   = DEF_MIN_WIDTH,
    parameter int unsigned DEAD_CYCLES = DEF_DEAD_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear_lost,
    abc_if.slave bus
);

    abc_chan_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_WIDTH   (MIN_WIDTH),
        .DEAD_CYCLES (DEAD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_chan1 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear_lost (clear_lost),
        .raw        (bus.raw1),
        .x          (bus.x1),
        .busy       (bus.busy1),
        .lost       (bus.lost1)
    );

    abc_chan_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_WIDTH   (MIN_WIDTH),
        .DEAD_CYCLES (DEAD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_chan2 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear_lost (clear_lost),
        .raw        (bus.raw2),
        .x          (bus.x2),
        .busy       (bus.busy2),
        .lost       (bus.lost2)
    );

endmodule

// File: tb/tb_abc_front_end.sv
// Directed bench for abc_front_end with default parameters.
module tb_abc_front_end;
    import abc_pkg::*;

    localparam int unsigned CNT_W = DEF_CNT_W;

    logic clk        = 1'b0;
    logic reset      = 1'b0;
    logic enable     = 1'b0;
    logic clear_lost = 1'b0;

    int tests  = 0;
    int fails  = 0;
    int x1_cnt = 0;
    int x2_cnt = 0;

    abc_if #(.CNT_W(CNT_W)) bus ();

    abc_front_end #(
        .SYNC_STAGES (2),
        .MIN_WIDTH   (2),
        .DEAD_CYCLES (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear_lost (clear_lost),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.x1 === 1'b1) x1_cnt <= x1_cnt + 1;
        if (bus.x2 === 1'b1) x2_cnt <= x2_cnt + 1;
    end

    task automatic check1(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic checkn(input string tag, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic checki(input string tag, input int got, input int exp);
        tests++;
        assert (got == exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; the next edge samples them.
    task automatic cyc(input logic r1, input logic r2);
        bus.raw1 = r1;
        bus.raw2 = r2;
        @(posedge clk);
        #1;
    endtask

    logic [11:0] pat;
    int          exp_lost;
    int          base1;
    int          base2;

    initial begin
        bus.raw1 = 1'b0;
        bus.raw2 = 1'b0;
        // bits 0..11: fire pulse (2 high) then four 1-cycle pulses inside the dead window
        pat = 12'b010101010011;

        #2 reset = 1'b1;
        #2;
        check1("rst_x1", bus.x1, 1'b0);
        check1("rst_x2", bus.x2, 1'b0);
        check1("rst_busy1", bus.busy1, 1'b0);
        check1("rst_busy2", bus.busy2, 1'b0);
        checkn("rst_lost1", bus.lost1, '0);
        checkn("rst_lost2", bus.lost2, '0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);

        // Long pulse on channel 1: one strobe after edge 4
        base1 = x1_cnt;
        base2 = x2_cnt;
        for (int k = 0; k < 16; k++) begin
            cyc(k < 10, 1'b0);
            check1("t1_x1", bus.x1, k == 4);
            check1("t1_x2", bus.x2, 1'b0);
            check1("t1_busy1", bus.busy1, (k >= 3) && (k <= 13));
        end
        cyc(1'b0, 1'b0);
        checki("t1_x1_count", x1_cnt - base1, 1);
        checki("t1_x2_count", x2_cnt - base2, 0);

        // Glitch narrower than MIN_WIDTH
        for (int k = 0; k < 8; k++) begin
            cyc(k == 0, 1'b0);
            check1("t2_x1", bus.x1, 1'b0);
            check1("t2_busy1", bus.busy1, k == 3);
        end
        checkn("t2_lost1", bus.lost1, '0);

        // Coincident pulses on both channels
        for (int k = 0; k < 16; k++) begin
            cyc(k < 5, k < 5);
            check1("t3_x1", bus.x1, k == 4);
            check1("t3_x2", bus.x2, k == 4);
        end
        cyc(1'b0, 1'b0);

        // Three 2-cycle pulses, later two fall in the dead window
        for (int k = 0; k < 18; k++) begin
            cyc((k == 0) || (k == 1) || (k == 5) || (k == 6) || (k == 10) || (k == 11), 1'b0);
            check1("t4_x1", bus.x1, k == 4);
            exp_lost = (k >= 12) ? 2 : ((k >= 7) ? 1 : 0);
            checkn("t4_lost1", bus.lost1, CNT_W'(exp_lost));
        end
        checkn("t4_lost2", bus.lost2, '0);

        // 20 more pulses: saturation at 15
        base1 = x1_cnt;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 12; k++) cyc(pat[k], 1'b0);
            exp_lost = (5 + 4 * r > 15) ? 15 : 5 + 4 * r;
            checkn("t5_lost1_round", bus.lost1, CNT_W'(exp_lost));
        end
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0);
        checkn("t5_lost1_sat", bus.lost1, CNT_W'(15));
        checki("t5_x1_count", x1_cnt - base1, 4);

        // clear_lost coincident with a lost edge: clear wins
        for (int k = 0; k < 12; k++) begin
            clear_lost = (k == 6);
            cyc(pat[k], 1'b0);
            if (k == 6)  checkn("t6_clear_wins", bus.lost1, '0);
            if (k == 11) checkn("t6_lost1_after", bus.lost1, CNT_W'(2));
        end
        clear_lost = 1'b0;
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0);
        checkn("t6_lost1_final", bus.lost1, CNT_W'(3));

        // Drop enable while in DEAD
        for (int k = 0; k < 7; k++) begin
            if (k == 6) enable = 1'b0;
            cyc(1'b1, 1'b0);
            if (k == 4) check1("t7_x1_fire", bus.x1, 1'b1);
            if (k == 6) check1("t7_busy1_dead", bus.busy1, 1'b1);
        end
        cyc(1'b1, 1'b0);
        check1("t7_busy1_off", bus.busy1, 1'b0);
        check1("t7_x1_off", bus.x1, 1'b0);
        checkn("t7_lost1_hold", bus.lost1, CNT_W'(3));
        clear_lost = 1'b1;
        cyc(1'b1, 1'b0);
        clear_lost = 1'b0;
        checkn("t7_clear_disabled", bus.lost1, '0);
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0);
            check1("t7_reen_x1", bus.x1, 1'b0);
            check1("t7_reen_busy1", bus.busy1, 1'b0);
        end
        for (int k = 0; k < 20; k++) begin
            cyc(((k >= 3) && (k <= 8)) || (k == 10), 1'b0);
            check1("t7_refire_x1", bus.x1, k == 7);
        end
        checkn("t7_lost1_refire", bus.lost1, CNT_W'(1));

        // Reset during ARM
        base1 = x1_cnt;
        base2 = x2_cnt;
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1);
        reset = 1'b1;
        #1;
        checkn("t8_lost1_async", bus.lost1, '0);
        check1("t8_x1", bus.x1, 1'b0);
        check1("t8_x2", bus.x2, 1'b0);
        check1("t8_busy1", bus.busy1, 1'b0);
        cyc(1'b0, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, 1'b0);
            check1("t8_post_x1", bus.x1, 1'b0);
            check1("t8_post_x2", bus.x2, 1'b0);
        end

        // Reset during FIRE
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0);
        check1("t9_busy1_pre", bus.busy1, 1'b1);
        reset = 1'b1;
        #1;
        check1("t9_busy1_async", bus.busy1, 1'b0);
        check1("t9_x1_async", bus.x1, 1'b0);
        cyc(1'b0, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, 1'b0);
            check1("t9_post_x1", bus.x1, 1'b0);
            check1("t9_post_busy1", bus.busy1, 1'b0);
        end
        checki("t9_x1_count", x1_cnt - base1, 0);
        checki("t9_x2_count", x2_cnt - base2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
